// File: rtl/booth_r4_seq_ctrl_if.sv
// Handshake and step-calculator bus between the Booth radix-4 sequencer and its neighbours.
// The slave side is the sequencer; the master side is the requester plus the step calculator.
interface booth_r4_seq_ctrl_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
);
  logic                  op_start;
  logic                  op_clear;
  logic [WIDTH-1:0]      multiplicand;
  logic [WIDTH-1:0]      multiplier;
  logic [WIDTH-1:0]      cal_a;
  logic [2*WIDTH-1:0]    cal_b;
  logic [2:0]            cal_x;
  logic [CNT_W-1:0]      cal_cnt;
  logic [2*WIDTH-1:0]    cal_result;
  logic                  op_done;
  logic [2*WIDTH-1:0]    result;

  modport slave (
    input  op_start, op_clear, multiplicand, multiplier, cal_result,
    output cal_a, cal_b, cal_x, cal_cnt, op_done, result
  );

  modport master (
    output op_start, op_clear, multiplicand, multiplier, cal_result,
    input  cal_a, cal_b, cal_x, cal_cnt, op_done, result
  );
endinterface

// File: rtl/booth_r4_seq_ctrl.sv
// Register/FSM stage for a signed radix-4 Booth multiplier: holds operands, accumulator and
// step count, and closes the loop around the external combinational Booth step calculator.
//
//   state | meaning
//   IDLE  | waiting for op_start; operands loaded on the accepting edge
//   BUSY  | one Booth step per edge, ITER edges in total
//   DONE  | product presented on result with op_done; held until op_clear/reset
module booth_r4_seq_ctrl #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  booth_r4_seq_ctrl_if.slave        bus
);

  localparam int ITER = WIDTH / 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic                 prev_q, prev_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      mplr_q  <= '0;
      prev_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mplr_q  <= mplr_d;
      prev_q  <= prev_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    mplr_d  = mplr_q;
    prev_d  = prev_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.op_start) begin
          a_d     = bus.multiplicand;
          mplr_d  = bus.multiplier;
          prev_d  = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Arithmetic shift keeps the top window sign-correct for negative multipliers.
        acc_d  = bus.cal_result;
        mplr_d = WIDTH'($signed(mplr_q) >>> 2);
        prev_d = mplr_q[1];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort discards everything, including any partial product.
    if (bus.op_clear) begin
      state_d = IDLE;
      a_d     = '0;
      mplr_d  = '0;
      prev_d  = 1'b0;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  assign bus.cal_a   = a_q;
  assign bus.cal_b   = acc_q;
  assign bus.cal_x   = {mplr_q[1:0], prev_q};
  assign bus.cal_cnt = cnt_q;
  assign bus.op_done = (state_q == DONE);
  assign bus.result  = (state_q == DONE) ? acc_q : '0;

endmodule

// File: tb/tb_booth_r4_seq_ctrl.sv
// Directed bench for booth_r4_seq_ctrl; includes a behavioural Booth step calculator.
module tb_booth_r4_seq_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  booth_r4_seq_ctrl_if #(.WIDTH(64), .CNT_W(8)) bus ();

  booth_r4_seq_ctrl #(.WIDTH(64), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Step calculator: add digit*A into the upper half, then arithmetic shift right by 2.
  logic signed [65:0] a_ext, addend, hi_sum;
  logic [129:0]       wide;
  always_comb begin
    a_ext  = {{2{bus.cal_a[63]}}, bus.cal_a};
    addend = '0;
    case (bus.cal_x)
      3'b001, 3'b010: addend = a_ext;
      3'b011:         addend = a_ext <<< 1;
      3'b100:         addend = -(a_ext <<< 1);
      3'b101, 3'b110: addend = -a_ext;
      default:        addend = '0;
    endcase
    hi_sum = $signed({{2{bus.cal_b[127]}}, bus.cal_b[127:64]}) + addend;
    wide   = {hi_sum, bus.cal_b[63:0]};
  end
  assign bus.cal_result = wide[129:2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    bus.op_start     = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(negedge clk);
    bus.op_start = 1'b0;
  endtask

  // Counts BUSY edges from the current negedge until op_done, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.op_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [127:0] exp);
    int cyc;
    start_op(a, b);
    wait_done(cyc);
    chk({tag, "_lat"}, 128'(cyc), 128'd32);
    chk({tag, "_res"}, bus.result, exp);
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    bus.op_clear = 1'b1;
    @(negedge clk);
    bus.op_clear = 1'b0;
  endtask

  initial begin
    int cyc;
    reset            = 1'b1;
    bus.op_start     = 1'b0;
    bus.op_clear     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_done",   128'(bus.op_done), 128'd0);
    chk("rst_result", bus.result, 128'd0);
    chk("rst_cal_a",  128'(bus.cal_a), 128'd0);
    chk("rst_cal_b",  bus.cal_b, 128'd0);
    chk("rst_cal_x",  128'(bus.cal_x), 128'd0);
    chk("rst_cnt",    128'(bus.cal_cnt), 128'd0);

    // 1: basic product, latency, hold in DONE
    start_op(64'd5, 64'd3);
    chk("t1_busy_res", bus.result, 128'd0);
    chk("t1_cal_a", 128'(bus.cal_a), 128'd5);
    wait_done(cyc);
    chk("t1_lat", 128'(cyc), 128'd32);
    chk("t1_res", bus.result, 128'd15);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t1_hold_done", 128'(bus.op_done), 128'd1);
      chk("t1_hold_res", bus.result, 128'd15);
    end
    clear_pulse();
    chk("t1_clr_done", 128'(bus.op_done), 128'd0);
    chk("t1_clr_res", bus.result, 128'd0);

    // 2: negative operands
    run_op("t2a", -64'sd7, 64'd6, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6);
    clear_pulse();
    run_op("t2b", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, {128{1'b1}});
    clear_pulse();

    // 3: extreme operands
    run_op("t3a", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           128'h4000_0000_0000_0000_0000_0000_0000_0000);
    clear_pulse();
    run_op("t3b", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
           128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001);
    clear_pulse();

    // 4: abort mid-operation
    start_op(64'd9, 64'd9);
    repeat (10) @(negedge clk);
    chk("t4_step", 128'(bus.cal_cnt), 128'd10);
    bus.op_clear = 1'b1;
    @(negedge clk);
    bus.op_clear = 1'b0;
    chk("t4_abort_done", 128'(bus.op_done), 128'd0);
    chk("t4_abort_b", bus.cal_b, 128'd0);
    chk("t4_abort_cnt", 128'(bus.cal_cnt), 128'd0);
    chk("t4_abort_x", 128'(bus.cal_x), 128'd0);
    @(negedge clk);
    chk("t4_idle_cnt", 128'(bus.cal_cnt), 128'd0);
    run_op("t4b", 64'd2, 64'd4, 128'd8);
    clear_pulse();

    // 5: op_start ignored while BUSY/DONE; clear beats start
    start_op(64'd3, 64'd4);
    repeat (4) @(negedge clk);
    bus.op_start     = 1'b1;
    bus.multiplicand = 64'd100;
    bus.multiplier   = 64'd100;
    @(negedge clk);
    bus.op_start = 1'b0;
    chk("t5_busy_a", 128'(bus.cal_a), 128'd3);
    wait_done(cyc);
    chk("t5_res", bus.result, 128'd12);
    bus.op_start = 1'b1;
    @(negedge clk);
    bus.op_start = 1'b0;
    chk("t5_done_res", bus.result, 128'd12);
    chk("t5_done_cnt", 128'(bus.cal_cnt), 128'd32);
    bus.op_clear     = 1'b1;
    bus.op_start     = 1'b1;
    bus.multiplicand = 64'd6;
    bus.multiplier   = 64'd7;
    @(negedge clk);
    bus.op_clear = 1'b0;
    chk("t5_clr_done", 128'(bus.op_done), 128'd0);
    chk("t5_noload_a", 128'(bus.cal_a), 128'd0);
    @(negedge clk);
    bus.op_start = 1'b0;
    chk("t5_load_a", 128'(bus.cal_a), 128'd6);
    chk("t5_load_cnt", 128'(bus.cal_cnt), 128'd0);
    wait_done(cyc);
    chk("t5b_lat", 128'(cyc), 128'd32);
    chk("t5b_res", bus.result, 128'd42);
    clear_pulse();

    // 6: reset during BUSY with op_start held
    @(negedge clk);
    bus.op_start     = 1'b1;
    bus.multiplicand = 64'd11;
    bus.multiplier   = 64'd3;
    repeat (4) @(negedge clk);
    chk("t6_busy_cnt", 128'(bus.cal_cnt), 128'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_rst_done", 128'(bus.op_done), 128'd0);
    chk("t6_rst_a", 128'(bus.cal_a), 128'd0);
    chk("t6_rst_b", bus.cal_b, 128'd0);
    chk("t6_rst_x", 128'(bus.cal_x), 128'd0);
    chk("t6_rst_cnt", 128'(bus.cal_cnt), 128'd0);
    chk("t6_rst_res", bus.result, 128'd0);
    @(negedge clk);
    bus.op_start = 1'b0;
    chk("t6_restart_a", 128'(bus.cal_a), 128'd11);
    chk("t6_restart_cnt", 128'(bus.cal_cnt), 128'd0);
    wait_done(cyc);
    chk("t6_lat", 128'(cyc), 128'd32);
    chk("t6_res", bus.result, 128'd33);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/booth_r4_seq_ctrl.md
Name: booth_r4_seq_ctrl

Overview:
Sequencer and state holder for the 64x64 signed radix-4 Booth multiplier. It latches the operands and drives the Booth step calculator with the multiplicand, the current partial product, the 3-bit Booth window and the step count. It captures the shifted step result each cycle and presents the final 128-bit product with a done flag. It is the register/FSM stage directly upstream of, and closing the loop around, the combinational Booth step calculator.

Parameters:
WIDTH, 64, operand width; even; product is 2*WIDTH bits
ITER, WIDTH/2, number of radix-4 steps (32 at default); derived, not overridden
CNT_W, 8, width of step counter and cal_cnt

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
op_start  in  1  start request; sampled only in IDLE
op_clear  in  1  synchronous abort/clear; highest priority after reset
multiplicand  in  WIDTH  signed operand A; sampled on accepted op_start
multiplier  in  WIDTH  signed operand B; sampled on accepted op_start
cal_a  out  WIDTH  registered multiplicand to step calculator
cal_b  out  2*WIDTH  current partial product (accumulator register)
cal_x  out  3  Booth window {mplr[1], mplr[0], prev_bit}
cal_cnt  out  CNT_W  current step index 0..ITER-1
cal_result  in  2*WIDTH  step calculator output (add-select, then ASR by 2); treated as combinational
op_done  out  1  high while in DONE
result  out  2*WIDTH  final signed product

Behaviour:
- Registers: a_reg (WIDTH), mplr (WIDTH, shift register), prev_bit (1), acc (2*WIDTH), cnt (CNT_W), state {IDLE, BUSY, DONE}.
- Reset (reset=1 at edge): state=IDLE and all registers 0. Result: op_done=0, result=0, cal_a=0, cal_b=0, cal_x=3'b000, cal_cnt=0.
- Priority each edge: reset > op_clear > FSM transition.
- op_clear in any state: same effect as reset. This aborts a BUSY operation with no partial result retained.
- IDLE: if op_start=1, load a_reg<=multiplicand, mplr<=multiplier, prev_bit<=0, acc<=0, cnt<=0, then go to BUSY. Otherwise hold.
- BUSY, every edge:
  - acc<=cal_result
  - mplr<=mplr>>2 (arithmetic shift; the shifted-out bits are unused)
  - prev_bit<=mplr[1]
  - cnt<=cnt+1
  - if cnt==ITER-1, go to DONE.
- op_start in BUSY or DONE is ignored. Operands presented then are not sampled.
- DONE:
  - op_done=1 and result=acc; both hold until op_clear or reset.
  - acc, mplr and cnt are frozen.
  - op_start does not restart; op_clear is required first.
- Latency: the load edge, then exactly ITER BUSY edges. op_done rises ITER cycles after the load edge (32 at default).
- cal_* are pure functions of registers with no input-to-output combinational path. cal_cnt=cnt. In IDLE/DONE cal_x reflects the frozen registers, and cal_result is ignored.
- Booth window encoding required of the calculator:
  - 000 or 111: +0
  - 001 or 010: +A
  - 011: +2A
  - 100: -2A
  - 101 or 110: -A
  - The calculator adds into acc[127:64] and then arithmetic-shifts right by 2.
- Signed two's complement throughout. The most negative operands (0x8000...0 x 0x8000...0) must give 2^126 with no overflow.
- result is 0 outside DONE.

Test Plan:
1. Reset, then op_start with A=5, B=3 -> op_done rises exactly 32 cycles after the load edge; result=128'd15; op_done stays high for 10 more idle cycles.
2. A=-7, B=6 -> result=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6 (-42). Then A=64'hFFFF_FFFF_FFFF_FFFF, B=1 -> result=all-ones (-1).
3. A=B=64'h8000_0000_0000_0000 -> result=128'h4000_0000_0000_0000_0000_0000_0000_0000. Then A=B=64'h7FFF_FFFF_FFFF_FFFF -> result=128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001.
4. Start A=9, B=9; at step 10 assert op_clear for one cycle -> next cycle state IDLE, cal_b=0, cal_cnt=0, op_done=0. A fresh start with A=2, B=4 gives result=8 after 32 cycles.
5. Start A=3, B=4; pulse op_start with A=100, B=100 at step 5 and again in DONE -> result=12 unchanged. Then assert op_clear and op_start on the same edge -> IDLE with no load; op_start alone on the next edge is accepted.
6. Assert reset in BUSY with op_start held high -> after the reset edge: IDLE, all outputs 0. The operation restarts on the first edge after reset deasserts, since op_start is still high.
